// File: rtl/ethernet_tx_arbiter.sv
// rtl/ethernet_tx_arbiter.sv - frame-level round-robin arbiter in front of ethernet_tx
// Optional stall watchdog with tx_abort output: define ETH_TX_ARB_TIMEOUT_EN.
module ethernet_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*48-1:0]   req_dst_mac,
  input  logic [NUM_REQ*16-1:0]   req_ethertype,
  input  logic [NUM_REQ*8-1:0]    req_data,
  input  logic [NUM_REQ-1:0]      req_data_valid,
  input  logic [NUM_REQ-1:0]      req_data_last,
  output logic [NUM_REQ-1:0]      req_data_ready,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    hdr_valid,
  output logic [47:0]             hdr_dst_mac,
  output logic [15:0]             hdr_ethertype,
  input  logic                    hdr_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  output logic                    tx_last,
`ifdef ETH_TX_ARB_TIMEOUT_EN
  output logic                    tx_abort,
`endif
  input  logic                    tx_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_GAP, ST_ABORT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [47:0]        mac_q, mac_d;
  logic [15:0]        type_q, type_d;
  logic [IFG_W-1:0]   ifg_q, ifg_d;
  logic               frame_done;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W:0]     sum;
  logic [IDX_W-1:0]   cand;

`ifdef ETH_TX_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0]    to_q, to_d;
`endif

  // First pending requester at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    grant_d        = grant_q;
    mac_d          = mac_q;
    type_d         = type_q;
    ifg_d          = ifg_q;
    frame_done     = 1'b0;
    hdr_valid      = 1'b0;
    tx_data        = 8'h00;
    tx_valid       = 1'b0;
    tx_last        = 1'b0;
    req_data_ready = '0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
    to_d           = to_q;
    tx_abort       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d = pick;
          grant_d = NUM_REQ'(1) << pick;
          mac_d   = req_dst_mac[48*int'(pick) +: 48];
          type_d  = req_ethertype[16*int'(pick) +: 16];
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        hdr_valid = 1'b1;
        if (hdr_ready) state_d = ST_DATA;
`ifdef ETH_TX_ARB_TIMEOUT_EN
        to_d = '0;
`endif
      end
      ST_DATA: begin
        tx_data        = req_data[8*int'(owner_q) +: 8];
        tx_valid       = req_data_valid[owner_q];
        tx_last        = req_data_last[owner_q];
        req_data_ready = grant_q & {NUM_REQ{tx_ready}};
        if (tx_valid && tx_ready) begin
          frame_done = tx_last;
`ifdef ETH_TX_ARB_TIMEOUT_EN
          to_d = '0;
        end else if (!tx_valid) begin
          if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_d    = '0;
            state_d = ST_ABORT;
          end else begin
            to_d = to_q + 1'b1;
          end
`endif
        end
      end
`ifdef ETH_TX_ARB_TIMEOUT_EN
      // Synthetic terminating beat so ethernet_tx closes the stalled frame.
      ST_ABORT: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        if (tx_ready) begin
          tx_abort   = 1'b1;
          frame_done = 1'b1;
        end
      end
`endif
      ST_GAP: begin
        if (ifg_q == IFG_W'(IFG_CYCLES - 1)) state_d = ST_IDLE;
        else ifg_d = ifg_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_done) begin
      rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      grant_d  = '0;
      ifg_d    = '0;
      state_d  = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      mac_q    <= '0;
      type_q   <= '0;
      ifg_q    <= '0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      mac_q    <= mac_d;
      type_q   <= type_d;
      ifg_q    <= ifg_d;
`ifdef ETH_TX_ARB_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign hdr_dst_mac   = mac_q;
  assign hdr_ethertype = type_q;

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// tb/tb_ethernet_tx_arbiter.sv - scoreboard bench for ethernet_tx_arbiter
module tb_ethernet_tx_arbiter;
  localparam int N   = 4;
  localparam int IFG = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*48-1:0] req_dst_mac;
  logic [N*16-1:0] req_ethertype;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_data_valid;
  logic [N-1:0]   req_data_last;
  logic [N-1:0]   req_data_ready;
  logic [N-1:0]   grant;
  logic           hdr_valid;
  logic [47:0]    hdr_dst_mac;
  logic [15:0]    hdr_ethertype;
  logic           hdr_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_last;
  logic           tx_ready;
`ifdef ETH_TX_ARB_TIMEOUT_EN
  logic           tx_abort;
`endif

  always #5 clk = ~clk;

  ethernet_tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_dst_mac(req_dst_mac), .req_ethertype(req_ethertype),
    .req_data(req_data), .req_data_valid(req_data_valid), .req_data_last(req_data_last),
    .req_data_ready(req_data_ready), .grant(grant),
    .hdr_valid(hdr_valid), .hdr_dst_mac(hdr_dst_mac), .hdr_ethertype(hdr_ethertype),
    .hdr_ready(hdr_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
`ifdef ETH_TX_ARB_TIMEOUT_EN
    .tx_abort(tx_abort),
`endif
    .tx_ready(tx_ready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [47:0] mac_tab [N];
  logic [15:0] et_tab  [N];
  logic [8:0]  src [N][$];
  logic [8:0]  exp_q [$];
  int          exp_grant_q [$];
  int          frames_left [N];
  bit          busy [N];
  bit          in_data, gap_chk, gap_arm, tgl_mode, rdy_phase;
  int          cur_owner, hold_left, held_cnt, idle_run, bytes_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = (frames_left[i] > 0) && !busy[i];
      req_data_valid[i] = src[i].size() > 0;
      req_data[8*i +: 8] = (src[i].size() > 0) ? src[i][0][7:0] : 8'h00;
      req_data_last[i]  = (src[i].size() > 0) ? src[i][0][8] : 1'b0;
    end
  endtask

  task automatic drive_hs();
    if (hdr_valid && hold_left > 0) begin
      hdr_ready = 1'b0;
      hold_left--;
    end else begin
      hdr_ready = 1'b1;
    end
    if (tgl_mode) begin
      tx_ready  = rdy_phase;
      rdy_phase = ~rdy_phase;
    end else begin
      tx_ready = 1'b1;
    end
  endtask

  task automatic load(input int i, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      src[i].push_back({(k == n - 1), base + 8'(k)});
      exp_q.push_back({(k == n - 1), base + 8'(k)});
    end
    exp_grant_q.push_back(i);
    frames_left[i]++;
    drive_req();
  endtask

  // Sampled on the falling edge, between DUT updates.
  task automatic monitor();
    logic [N-1:0] exp_rdy;
    logic [8:0]   e;
    int           o;
    exp_rdy = (in_data && tx_ready) ? (N'(1) << cur_owner) : '0;
    check("data_ready", req_data_ready, exp_rdy);
    if (grant != 0 && gap_arm) begin
      if (gap_chk) check("idle_gap", idle_run, IFG + 1);
      gap_arm = 1'b0;
    end
    if (grant == 0) idle_run++;
    if (hdr_valid && !hdr_ready) begin
      held_cnt++;
      if (exp_grant_q.size() == 0) check("hdr_unexpected", hdr_valid, 0);
      else begin
        check("hold_mac", hdr_dst_mac, mac_tab[exp_grant_q[0]]);
        check("hold_type", hdr_ethertype, et_tab[exp_grant_q[0]]);
      end
    end
    if (hdr_valid && hdr_ready) begin
      if (exp_grant_q.size() == 0) check("hdr_unexpected", hdr_valid, 0);
      else begin
        o = exp_grant_q.pop_front();
        check("grant", grant, N'(1) << o);
        check("hdr_mac", hdr_dst_mac, mac_tab[o]);
        check("hdr_type", hdr_ethertype, et_tab[o]);
        cur_owner = o;
        in_data   = 1'b1;
        busy[o]   = 1'b1;
        frames_left[o]--;
      end
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("tx_unexpected", tx_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("tx_byte", {tx_last, tx_data}, e);
        bytes_seen++;
        if (tx_last) begin
          in_data         = 1'b0;
          busy[cur_owner] = 1'b0;
          gap_arm         = 1'b1;
          idle_run        = 0;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (req_data_valid[i] && req_data_ready[i]) void'(src[i].pop_front());
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive_req();
    drive_hs();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() > 0 || exp_grant_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    check(tag, exp_q.size() + exp_grant_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      mac_tab[i]  = 48'h0200_0000_0000 + 48'(i * 17);
      et_tab[i]   = 16'h0800 + 16'(i);
      src[i].delete();
      frames_left[i] = 0;
      busy[i]     = 1'b0;
    end
    mac_tab[1] = 48'h0A0B0C0D0E0F;
    et_tab[1]  = 16'h0806;
    for (int i = 0; i < N; i++) begin
      req_dst_mac[48*i +: 48] = mac_tab[i];
      req_ethertype[16*i +: 16] = et_tab[i];
    end
    in_data = 0; gap_chk = 0; gap_arm = 0; tgl_mode = 0; rdy_phase = 1;
    cur_owner = 0; hold_left = 0; held_cnt = 0; idle_run = 0; bytes_seen = 0;
    rst_n = 1'b0; hdr_ready = 1'b1; tx_ready = 1'b1;
    drive_req();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_ready", req_data_ready, 0);
    check("rst_mac", hdr_dst_mac, 0);
    check("rst_type", hdr_ethertype, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness with 0, 2, 3 continuously pending: 0, 2, 3, 0.
    gap_chk = 1'b1;
    load(0, 2, 8'h10);
    load(2, 2, 8'h20);
    load(3, 2, 8'h30);
    load(0, 2, 8'h18);
    wait_done("rr_done", 300);
    gap_chk = 1'b0;
    repeat (IFG + 2) step();

    // Single requester, latency and gap.
    load(1, 4, 8'h41);
    check("lat_before", grant, 0);
    step();
    check("lat_grant", grant, 4'b0010);
    check("lat_hdr_valid", hdr_valid, 1);
    wait_done("single_done", 100);
    for (int k = 0; k < IFG; k++) begin
      check("gap_quiet", {grant, hdr_valid, tx_valid, req_data_ready}, 0);
      step();
    end
    step();

    // Header backpressure.
    hold_left = 5;
    held_cnt  = 0;
    load(2, 2, 8'h50);
    wait_done("hold_done", 100);
    check("hdr_held", held_cnt, 5);
    repeat (IFG + 2) step();

    // tx_ready toggling.
    tgl_mode  = 1'b1;
    rdy_phase = 1'b1;
    load(3, 3, 8'h60);
    wait_done("toggle_done", 100);
    tgl_mode = 1'b0;
    repeat (IFG + 2) step();

    // Single-byte frame leaves rr_ptr at 1, then reset mid-frame.
    load(0, 1, 8'h70);
    wait_done("onebyte_done", 100);
    repeat (IFG + 2) step();
    bytes_seen = 0;
    load(2, 4, 8'h80);
    begin
      int k = 0;
      while (bytes_seen < 1 && k < 100) begin
        step();
        k++;
      end
    end
    check("rst_wait", bytes_seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort_grant", grant, 0);
    check("abort_hdr_valid", hdr_valid, 0);
    check("abort_tx_valid", tx_valid, 0);
    check("abort_tx_last", tx_last, 0);
    check("abort_ready", req_data_ready, 0);
    for (int i = 0; i < N; i++) begin
      src[i].delete();
      frames_left[i] = 0;
      busy[i] = 1'b0;
    end
    exp_q.delete();
    exp_grant_q.delete();
    in_data = 1'b0;
    gap_arm = 1'b0;
    load(0, 2, 8'h90);
    load(2, 4, 8'h80);
    step();
    step();
    rst_n = 1'b1;
    wait_done("after_rst_done", 200);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
